// File: rtl/stream_msg_buffer_if.sv
// ============================================================================
// Module  : stream_msg_buffer_if
// Brief   : Valid/ready stream and message FIFO signal bundle.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface stream_msg_buffer_if #(
  parameter int DATA_WIDTH     = 26,
  parameter int MSG_WIDTH      = 32,
  parameter int MSG_DEPTH_LOG2 = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;
  logic [MSG_WIDTH-1:0]      msg_wdata;
  logic                      msg_wrreq;
  logic                      msg_rdreq;
  logic                      msg_sclr;
  logic [MSG_WIDTH-1:0]      msg_q;
  logic [MSG_DEPTH_LOG2-1:0] msg_usedw;
  logic                      msg_empty;
  logic                      msg_full;

  modport master (
    output in_valid, in_data, out_ready, msg_wdata, msg_wrreq, msg_rdreq, msg_sclr,
    input  in_ready, out_valid, out_data, msg_q, msg_usedw, msg_empty, msg_full
  );

  modport slave (
    input  in_valid, in_data, out_ready, msg_wdata, msg_wrreq, msg_rdreq, msg_sclr,
    output in_ready, out_valid, out_data, msg_q, msg_usedw, msg_empty, msg_full
  );
endinterface

`default_nettype wire

// File: rtl/stream_msg_buffer.sv
// ============================================================================
// Module  : stream_msg_buffer
// Brief   : Skid-buffered stream register plus independent show-ahead FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stream_msg_buffer #(
  parameter int DATA_WIDTH     = 26,
  parameter int MSG_WIDTH      = 32,
  parameter int MSG_DEPTH_LOG2 = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  stream_msg_buffer_if.slave  bus
);

  localparam int                  DEPTH      = 1 << MSG_DEPTH_LOG2;
  localparam logic [MSG_DEPTH_LOG2:0] FULL_COUNT = (MSG_DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------------------------------------------------------- stream
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q,  skid_data_d;
  logic                  in_ready_q,   in_ready_d;
  logic                  accept;
  logic                  main_load;

  assign accept    = bus.in_valid & in_ready_q;
  assign main_load = ~out_valid_q | bus.out_ready;

  // in_ready_q is low whenever the skid is full, so the skid never overflows.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_data_d = bus.in_data;
        end
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = bus.in_data;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // ---------------------------------------------------------------- FIFO
  logic [MSG_WIDTH-1:0]      mem [DEPTH];
  logic [MSG_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [MSG_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [MSG_DEPTH_LOG2:0]   count_q,  count_d;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      wr_en;
  logic                      rd_en;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign wr_en      = bus.msg_wrreq & ~fifo_full;
  assign rd_en      = bus.msg_rdreq & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.msg_sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is unreset; a stale word is unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.msg_wdata;
    end
  end

  assign bus.msg_q     = fifo_empty ? '0 : mem[rd_ptr_q];
  assign bus.msg_usedw = count_q[MSG_DEPTH_LOG2-1:0];
  assign bus.msg_empty = fifo_empty;
  assign bus.msg_full  = fifo_full;

endmodule

`default_nettype wire

// File: tb/tb_stream_msg_buffer.sv
// ============================================================================
// Module  : tb_stream_msg_buffer
// Brief   : Scoreboard bench for the stream register and message FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_msg_buffer;

  localparam int DW    = 26;
  localparam int MW    = 32;
  localparam int LOG2  = 8;
  localparam int DEPTH = 1 << LOG2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  stream_msg_buffer_if #(.DATA_WIDTH(DW), .MSG_WIDTH(MW), .MSG_DEPTH_LOG2(LOG2)) bus ();

  stream_msg_buffer #(.DATA_WIDTH(DW), .MSG_WIDTH(MW), .MSG_DEPTH_LOG2(LOG2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sq[$];   // words accepted and not yet emitted, in order
  logic [MW-1:0] fq[$];   // FIFO contents, head at index 0

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the expected word on every emit, checks hold while stalled.
  logic          stalled = 1'b0;
  logic [DW-1:0] held;
  always @(negedge clk) begin
    if (!reset_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data",  64'(bus.out_data),  64'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream_extra: got 0x%0h expected no word at %0t", bus.out_data, $time);
        end else begin
          check("stream_data", 64'(bus.out_data), 64'(sq.pop_front()));
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic stream_cycle(input bit v, input logic [DW-1:0] d, input bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    if (v && bus.in_ready) sq.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic check_fifo();
    check("fifo_q",     64'(bus.msg_q),     (fq.size() == 0) ? 64'd0 : 64'(fq[0]));
    check("fifo_usedw", 64'(bus.msg_usedw), 64'(fq.size() % DEPTH));
    check("fifo_empty", 64'(bus.msg_empty), 64'(fq.size() == 0));
    check("fifo_full",  64'(bus.msg_full),  64'(fq.size() == DEPTH));
  endtask

  task automatic fifo_op(input bit wr, input logic [MW-1:0] wd, input bit rd, input bit clr);
    bit do_w, do_r;
    bus.msg_wrreq = wr;
    bus.msg_wdata = wd;
    bus.msg_rdreq = rd;
    bus.msg_sclr  = clr;
    if (rd && !clr && fq.size() > 0) check("fifo_rd_data", 64'(bus.msg_q), 64'(fq[0]));
    if (clr) begin
      fq.delete();
    end else begin
      do_w = wr && fq.size() < DEPTH;
      do_r = rd && fq.size() > 0;
      if (do_r) void'(fq.pop_front());
      if (do_w) fq.push_back(wd);
    end
    @(posedge clk); #1;
    bus.msg_wrreq = 1'b0;
    bus.msg_rdreq = 1'b0;
    bus.msg_sclr  = 1'b0;
    check_fifo();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sq.delete();
    fq.delete();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_empty",     64'(bus.msg_empty), 64'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rel_in_ready",  64'(bus.in_ready),  64'd1);
  endtask

  task automatic drain();
    int k;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (sq.size() > 0 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_left", 64'(sq.size()), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.msg_wdata = '0;
    bus.msg_wrreq = 1'b0;
    bus.msg_rdreq = 1'b0;
    bus.msg_sclr  = 1'b0;
    reset_n       = 1'b0;
    do_reset();

    // Streaming at full rate: each word appears one cycle after acceptance.
    for (int i = 1; i <= 5; i++) begin
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      stream_cycle(1'b1, DW'(i), 1'b1);
      check("lat_valid", 64'(bus.out_valid), 64'd1);
      check("lat_data",  64'(bus.out_data),  64'(i));
    end
    drain();

    // Stall: main then skid fill, in_ready drops, release drains in order.
    stream_cycle(1'b1, DW'(26'h10), 1'b0);
    stream_cycle(1'b1, DW'(26'h11), 1'b0);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    stream_cycle(1'b1, DW'(26'h12), 1'b0);
    stream_cycle(1'b1, DW'(26'h12), 1'b0);
    stream_cycle(1'b1, DW'(26'h12), 1'b1);
    stream_cycle(1'b1, DW'(26'h13), 1'b1);
    drain();

    for (int i = 0; i < 10000; i++) begin
      stream_cycle(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
    end
    for (int i = 0; i < 2000; i++) begin
      stream_cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();

    // FIFO directed sequence.
    check_fifo();
    fifo_op(1'b1, 32'hA, 1'b0, 1'b0);
    fifo_op(1'b1, 32'hB, 1'b0, 1'b0);
    fifo_op(1'b1, 32'hC, 1'b0, 1'b0);
    check("abc_q",     64'(bus.msg_q),     64'hA);
    check("abc_usedw", 64'(bus.msg_usedw), 64'd3);
    fifo_op(1'b0, '0, 1'b1, 1'b0);
    check("pop_q",     64'(bus.msg_q),     64'hB);
    check("pop_usedw", 64'(bus.msg_usedw), 64'd2);
    fifo_op(1'b0, '0, 1'b0, 1'b1);

    for (int i = 0; i < DEPTH; i++) fifo_op(1'b1, MW'($urandom), 1'b0, 1'b0);
    check("full_flag",  64'(bus.msg_full),  64'd1);
    check("full_usedw", 64'(bus.msg_usedw), 64'd0);
    check("full_empty", 64'(bus.msg_empty), 64'd0);
    fifo_op(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    fifo_op(1'b1, 32'hFEED_F00D, 1'b1, 1'b0);
    check("full_rw_usedw", 64'(bus.msg_usedw), 64'd255);
    for (int i = 0; i < DEPTH - 1; i++) fifo_op(1'b0, '0, 1'b1, 1'b0);
    check("drained_empty", 64'(bus.msg_empty), 64'd1);
    check("drained_q",     64'(bus.msg_q),     64'd0);

    for (int i = 0; i < 5; i++) fifo_op(1'b1, MW'($urandom), 1'b0, 1'b0);
    fifo_op(1'b1, 32'h5555, 1'b1, 1'b1);
    check("sclr_empty", 64'(bus.msg_empty), 64'd1);
    check("sclr_usedw", 64'(bus.msg_usedw), 64'd0);
    fifo_op(1'b0, '0, 1'b1, 1'b0);
    check("empty_rd_usedw", 64'(bus.msg_usedw), 64'd0);
    fifo_op(1'b1, 32'h77, 1'b1, 1'b0);
    check("empty_rw_usedw", 64'(bus.msg_usedw), 64'd1);

    for (int i = 0; i < 3000; i++) begin
      fifo_op(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, MW'($urandom),
              ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
              ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
